// File: rtl/prog_lut_eval.sv
// Programmable truth-table evaluator with valid/ready request stream and a reload sweep.
// Optional table readback port is enabled by defining LUT_READBACK_EN.
module prog_lut_eval #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0] INIT = 16'hCE40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_vec,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             cfg_reload,
`ifdef LUT_READBACK_EN
  input  logic [N_IN-1:0]  rb_addr,
  output logic [N_OUT-1:0] rb_data,
`endif
  output logic             busy
);

  localparam int DEPTH = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_ROW = N_IN'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_nxt;
  logic [N_IN-1:0]  ptr;
  logic [N_OUT-1:0] lut     [DEPTH];
  logic [N_OUT-1:0] init_tab[DEPTH];
  logic             vld_p1;
  logic [N_OUT-1:0] vec_p1;
  logic             accept;

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      init_tab[r] = INIT[r*N_OUT +: N_OUT];
    end
  end

  assign busy     = (state == SWEEP);
  assign in_ready = !busy && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == SWEEP) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_reload) state_nxt = SWEEP;
      SWEEP:   if (ptr == LAST_ROW) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Table storage: reset restores every row at once; sweep has priority over writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) lut[r] <= init_tab[r];
    end else if (state == SWEEP) begin
      lut[ptr] <= init_tab[ptr];
    end else if (cfg_we) begin
      lut[cfg_addr] <= cfg_data;
    end
  end

  // Stage p1: registered lookup result; reads see the row before any same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vec_p1 <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      vec_p1 <= lut[in_vec];
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_vec   = vec_p1;

`ifdef LUT_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) rb_data <= '0;
    else     rb_data <= lut[rb_addr];
  end
`endif

endmodule

// File: tb/tb_prog_lut_eval.sv
// Directed self-checking bench for prog_lut_eval (default table = A.B'.D + B.C.D' + A.C).
// With LUT_READBACK_EN defined, a second 3-in/2-out instance exercises readback.
module tb_prog_lut_eval;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, cfg_we, cfg_reload;
  logic       in_ready, out_valid, busy;
  logic [3:0] in_vec, cfg_addr;
  logic [0:0] cfg_data, out_vec;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

`ifdef LUT_READBACK_EN
  logic [3:0] rb_addr;
  logic [0:0] rb_data;
  logic       s_in_valid, s_in_ready, s_out_valid, s_cfg_we, s_busy;
  logic [2:0] s_in_vec, s_cfg_addr, s_rb_addr;
  logic [1:0] s_out_vec, s_cfg_data, s_rb_data;
`endif

  prog_lut_eval dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_reload(cfg_reload),
`ifdef LUT_READBACK_EN
    .rb_addr(rb_addr), .rb_data(rb_data),
`endif
    .busy(busy)
  );

`ifdef LUT_READBACK_EN
  prog_lut_eval #(.N_IN(3), .N_OUT(2), .INIT(16'hFFFF)) dut_rb (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_vec(s_in_vec),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_vec(s_out_vec),
    .cfg_we(s_cfg_we), .cfg_addr(s_cfg_addr), .cfg_data(s_cfg_data), .cfg_reload(1'b0),
    .rb_addr(s_rb_addr), .rb_data(s_rb_data), .busy(s_busy)
  );
`endif

  function automatic logic ref_f(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (a & ~b & d) | (b & c & ~d) | (a & c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval_all(input string tag);
    out_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      in_valid = 1'b1;
      in_vec   = 4'(v);
      tick();
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk($sformatf("%s_row%0d", tag, v), 32'(out_vec), 32'(ref_f(4'(v))));
    end
    in_valid = 1'b0;
    tick();
    chk({tag, "_clear"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_reload = 1'b0;
`ifdef LUT_READBACK_EN
    rb_addr = '0; s_in_valid = 1'b0; s_in_vec = '0; s_cfg_we = 1'b0;
    s_cfg_addr = '0; s_cfg_data = '0; s_rb_addr = '0;
`endif
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vec",   32'(out_vec),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    eval_all("post_reset");

    // Backpressure on row A
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 4'hA;
    tick();
    chk("bp_vld", 32'(out_valid), 32'd1);
    chk("bp_vec", 32'(out_vec),   32'd1);
    in_vec = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_rdy", 32'(in_ready),  32'd0);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_vec", 32'(out_vec),   32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("bp_consumed", 32'(out_valid), 32'd0);

    // Same-cycle write and eval of row 6 returns the old row
    in_valid = 1'b1; in_vec = 4'd6; cfg_we = 1'b1; cfg_addr = 4'd6; cfg_data = 1'b0;
    tick();
    chk("rbw_old", 32'(out_vec), 32'd1);
    cfg_we = 1'b0;
    tick();
    chk("rbw_new", 32'(out_vec), 32'd0);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 1'b1;
    tick();
    cfg_addr = 4'd9; cfg_data = 1'b0;
    tick();
    cfg_we = 1'b0; in_valid = 1'b1; in_vec = 4'd0;
    tick();
    chk("wr_row0", 32'(out_vec), 32'd1);
    in_vec = 4'd9;
    tick();
    chk("wr_row9", 32'(out_vec), 32'd0);
    in_valid = 1'b0;
    tick();

    // Reload sweep, with a write landing in the reload cycle and one ignored while busy
    cfg_reload = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 1'b1;
    tick();
    cfg_reload = 1'b0; cfg_we = 1'b0; in_valid = 1'b1; in_vec = 4'd5;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sweep_busy%0d", i), 32'(busy),      32'd1);
      chk($sformatf("sweep_rdy%0d", i),  32'(in_ready),  32'd0);
      chk($sformatf("sweep_vld%0d", i),  32'(out_valid), 32'd0);
      cfg_we = (i == 10); cfg_addr = 4'd0; cfg_data = 1'b1;
      cfg_reload = (i == 12);
      tick();
    end
    cfg_we = 1'b0; cfg_reload = 1'b0; in_valid = 1'b0;
    chk("sweep_done", 32'(busy), 32'd0);
    eval_all("post_reload");

    // Reset in the middle of a sweep while an output is held
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 4'd6;
    tick();
    in_valid = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_reload = 1'b1;
    tick();
    cfg_reload = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_busy", 32'(busy),      32'd1);
    chk("mid_vld",  32'(out_valid), 32'd1);
    chk("mid_vec",  32'(out_vec),   32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_sweep_vld",  32'(out_valid), 32'd0);
    chk("rst_sweep_busy", 32'(busy),      32'd0);
    eval_all("post_rst_sweep");

`ifdef LUT_READBACK_EN
    s_cfg_we = 1'b1; s_cfg_addr = 3'd5; s_cfg_data = 2'b10; s_rb_addr = 3'd5;
    tick();
    s_cfg_we = 1'b0;
    chk("rb_prewrite", 32'(s_rb_data), 32'h3);
    tick();
    chk("rb_written",  32'(s_rb_data), 32'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
